// File: rtl/smi_frame_scheduler_x4_pkg.sv
// Shared definitions for the 4-port SMI frame scheduler: FSM encoding,
// quota handling and the end-of-frame control mask.
package smi_frame_scheduler_x4_pkg;

  localparam int NumPorts        = 4;
  localparam int QuotaZeroFrames = 16;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } schedState_e;

  typedef struct packed {
    logic       found;
    logic [1:0] port;
  } rrPick_t;

  // Eofc carries a byte count for the last flit, so only log2(2*FlitWidth) bits are meaningful.
  function automatic logic [7:0] eofcMask(input int flitWidth);
    return 8'(2 * flitWidth - 1);
  endfunction

  function automatic logic [4:0] quotaFrames(input logic [3:0] quota);
    return (quota == 4'd0) ? 5'(QuotaZeroFrames) : {1'b0, quota};
  endfunction

endpackage

// File: rtl/smi_frame_scheduler_x4_fifo.sv
// Output link buffer: a show-ahead FIFO with ready/stop handshakes on both sides.
module selfLinkBufferFifoS #(
  parameter int Width     = 24,
  parameter int Depth     = 16,
  parameter int IndexSize = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inReady_i,
  input  logic [Width-1:0] inData_i,
  output logic             inStop_o,
  output logic             outReady_o,
  output logic [Width-1:0] outData_o,
  input  logic             outStop_i
);

  localparam logic [IndexSize:0]   DepthC  = (IndexSize + 1)'(Depth);
  localparam logic [IndexSize-1:0] LastIdx = IndexSize'(Depth - 1);

  logic [Width-1:0]     mem_q [Depth];
  logic [IndexSize-1:0] wrPtr_q;
  logic [IndexSize-1:0] rdPtr_q;
  logic [IndexSize:0]   count_q;
  logic                 push;
  logic                 pop;

  assign inStop_o   = (count_q == DepthC);
  assign outReady_o = (count_q != '0);
  assign outData_o  = mem_q[rdPtr_q];
  assign push       = inReady_i & ~inStop_o;
  assign pop        = outReady_o & ~outStop_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) wrPtr_q <= (wrPtr_q == LastIdx) ? '0 : wrPtr_q + 1'b1;
      if (pop)  rdPtr_q <= (rdPtr_q == LastIdx) ? '0 : rdPtr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q] <= inData_i;
  end

endmodule

// File: rtl/smi_frame_scheduler_x4.sv
// Four-input SMI frame scheduler: registers each input, grants whole frames
// round-robin with a per-port frames-per-turn quota, and buffers the result.
module smi_frame_scheduler_x4
  import smi_frame_scheduler_x4_pkg::*;
#(
  parameter int FlitWidth     = 2,
  parameter int FifoSize      = 16,
  parameter int FifoIndexSize = 4
) (
  input  logic                   clk,
  input  logic                   arstn,
  input  logic                   smiInReady0,
  input  logic [7:0]             smiInEofc0,
  input  logic [FlitWidth*8-1:0] smiInData0,
  output logic                   smiInStop0,
  input  logic                   smiInReady1,
  input  logic [7:0]             smiInEofc1,
  input  logic [FlitWidth*8-1:0] smiInData1,
  output logic                   smiInStop1,
  input  logic                   smiInReady2,
  input  logic [7:0]             smiInEofc2,
  input  logic [FlitWidth*8-1:0] smiInData2,
  output logic                   smiInStop2,
  input  logic                   smiInReady3,
  input  logic [7:0]             smiInEofc3,
  input  logic [FlitWidth*8-1:0] smiInData3,
  output logic                   smiInStop3,
  output logic                   smiOutReady,
  output logic [7:0]             smiOutEofc,
  output logic [FlitWidth*8-1:0] smiOutData,
  input  logic                   smiOutStop,
  input  logic [3:0]             cfgEnable,
  input  logic [15:0]            cfgQuota,
  output logic                   schedGrantValid,
  output logic [1:0]             schedGrantPort
);

  localparam int         DataW    = FlitWidth * 8;
  localparam int         FifoW    = (FlitWidth + 1) * 8;
  localparam logic [7:0] EofcMask = eofcMask(FlitWidth);

  logic [3:0]       inValid;
  logic [7:0]       inEofc [NumPorts];
  logic [DataW-1:0] inData [NumPorts];

  logic [3:0]       ready_q;
  logic [3:0]       last_q;
  logic [7:0]       eofc_q [NumPorts];
  logic [DataW-1:0] data_q [NumPorts];
  logic [3:0]       halt;
  logic [3:0]       stop;
  logic [3:0]       accept;
  logic [3:0]       nextReq;

  schedState_e state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [3:0]  quota_q, quota_d;
  rrPick_t     pick;
  logic        lastAccept;

  logic [1:0]       rstSync_q;
  logic             fifoFull;
  logic [FifoW-1:0] fifoWrData;
  logic [FifoW-1:0] fifoRdData;

  assign inValid   = {smiInReady3, smiInReady2, smiInReady1, smiInReady0};
  assign inEofc[0] = smiInEofc0;
  assign inEofc[1] = smiInEofc1;
  assign inEofc[2] = smiInEofc2;
  assign inEofc[3] = smiInEofc3;
  assign inData[0] = smiInData0;
  assign inData[1] = smiInData1;
  assign inData[2] = smiInData2;
  assign inData[3] = smiInData3;

  assign {smiInStop3, smiInStop2, smiInStop1, smiInStop0} = stop;

  // Lowest offset from base wins, so base itself has top priority and base-1 comes last.
  function automatic rrPick_t rrSelect(input logic [3:0] req, input logic [1:0] base);
    rrPick_t    r;
    logic [1:0] idx;
    r = '0;
    for (int i = 3; i >= 0; i--) begin
      idx = base + 2'(i);
      if (req[idx]) begin
        r.found = 1'b1;
        r.port  = idx;
      end
    end
    return r;
  endfunction

  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      halt[p] = !((state_q == XFER) && (grant_q == 2'(p)) && !fifoFull);
    end
  end

  assign stop       = ready_q & halt;
  assign accept     = ready_q & ~halt;
  assign lastAccept = accept[grant_q] & last_q[grant_q];

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      ready_q <= '0;
    end else begin
      for (int p = 0; p < NumPorts; p++) begin
        if (!stop[p]) ready_q[p] <= inValid[p];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < NumPorts; p++) begin
      if (!stop[p] && inValid[p]) begin
        eofc_q[p] <= inEofc[p] & EofcMask;
        data_q[p] <= inData[p];
        last_q[p] <= (inEofc[p] != 8'h00);
      end
    end
  end

  // The granted port's own eligibility is judged by the flit arriving behind the one being consumed.
  always_comb begin
    nextReq          = ready_q;
    nextReq[grant_q] = inValid[grant_q];
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    quota_d = quota_q;
    pick    = '0;
    unique case (state_q)
      IDLE: begin
        pick = rrSelect(ready_q & cfgEnable, ptr_q);
        if (pick.found) begin
          state_d = XFER;
          grant_d = pick.port;
          quota_d = cfgQuota[{pick.port, 2'b00} +: 4];
        end
      end
      XFER: begin
        if (lastAccept) begin
          if ((quotaFrames(quota_q) > 5'd1) && inValid[grant_q] && cfgEnable[grant_q]) begin
            quota_d = quota_q - 4'd1;
          end else begin
            ptr_d = grant_q + 2'd1;
            pick  = rrSelect(nextReq & cfgEnable, grant_q + 2'd1);
            if (pick.found) begin
              grant_d = pick.port;
              quota_d = cfgQuota[{pick.port, 2'b00} +: 4];
            end else begin
              state_d = IDLE;
              quota_d = '0;
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      quota_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      quota_q <= quota_d;
    end
  end

  assign schedGrantValid = (state_q == XFER);
  assign schedGrantPort  = grant_q;

  // Asserts with arstn, releases synchronously to clk.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) rstSync_q <= 2'b00;
    else        rstSync_q <= {rstSync_q[0], 1'b1};
  end

  assign fifoWrData = {eofc_q[grant_q], data_q[grant_q]};

  selfLinkBufferFifoS #(
    .Width    (FifoW),
    .Depth    (FifoSize),
    .IndexSize(FifoIndexSize)
  ) u_outFifo (
    .clk       (clk),
    .rst_n     (rstSync_q[1]),
    .inReady_i (accept[grant_q]),
    .inData_i  (fifoWrData),
    .inStop_o  (fifoFull),
    .outReady_o(smiOutReady),
    .outData_o (fifoRdData),
    .outStop_i (smiOutStop)
  );

  assign smiOutEofc = fifoRdData[FifoW-1 -: 8];
  assign smiOutData = fifoRdData[DataW-1:0];

endmodule

// File: tb/tb_smi_frame_scheduler_x4.sv
// Directed bench for smi_frame_scheduler_x4: single-flit vectors from a table,
// then multi-cycle arbitration, backpressure and reset sequences with a stream checker.
module tb_smi_frame_scheduler_x4;

  logic        clk;
  logic        arstn;
  logic [3:0]  inReady;
  logic [7:0]  inEofc [4];
  logic [15:0] inData [4];
  wire  [3:0]  inStop;
  logic        smiOutReady;
  logic [7:0]  smiOutEofc;
  logic [15:0] smiOutData;
  logic        smiOutStop;
  logic [3:0]  cfgEnable;
  logic [15:0] cfgQuota;
  logic        schedGrantValid;
  logic [1:0]  schedGrantPort;

  int numCompared;
  int numMismatched;

  logic [3:0]  srcOn;
  int          srcLen [4];
  int          srcFrame [4];
  int          srcFlit [4];
  bit          randStop;
  logic [23:0] rxQ [$];
  bit          rxStarted;
  int          rxGaps;

  typedef struct {
    int          port;
    logic [7:0]  eofc;
    logic [15:0] data;
    logic [7:0]  expEofc;
    logic [15:0] expData;
  } vec_t;

  vec_t vecs [5];

  smi_frame_scheduler_x4 #(
    .FlitWidth    (2),
    .FifoSize     (16),
    .FifoIndexSize(4)
  ) dut (
    .clk            (clk),
    .arstn          (arstn),
    .smiInReady0    (inReady[0]),
    .smiInEofc0     (inEofc[0]),
    .smiInData0     (inData[0]),
    .smiInStop0     (inStop[0]),
    .smiInReady1    (inReady[1]),
    .smiInEofc1     (inEofc[1]),
    .smiInData1     (inData[1]),
    .smiInStop1     (inStop[1]),
    .smiInReady2    (inReady[2]),
    .smiInEofc2     (inEofc[2]),
    .smiInData2     (inData[2]),
    .smiInStop2     (inStop[2]),
    .smiInReady3    (inReady[3]),
    .smiInEofc3     (inEofc[3]),
    .smiInData3     (inData[3]),
    .smiInStop3     (inStop[3]),
    .smiOutReady    (smiOutReady),
    .smiOutEofc     (smiOutEofc),
    .smiOutData     (smiOutData),
    .smiOutStop     (smiOutStop),
    .cfgEnable      (cfgEnable),
    .cfgQuota       (cfgQuota),
    .schedGrantValid(schedGrantValid),
    .schedGrantPort (schedGrantPort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    numCompared++;
    if (actual !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic driveSources();
    for (int p = 0; p < 4; p++) begin
      inReady[p] = srcOn[p];
      inData[p]  = {4'(p), 8'(srcFrame[p]), 4'(srcFlit[p])};
      inEofc[p]  = (srcFlit[p] == srcLen[p] - 1) ? 8'hF2 : 8'h00;
    end
  endtask

  task automatic startSources(input logic [3:0] mask, input int l0, input int l1, input int l2, input int l3);
    srcLen[0] = l0;
    srcLen[1] = l1;
    srcLen[2] = l2;
    srcLen[3] = l3;
    for (int p = 0; p < 4; p++) begin
      srcFrame[p] = 0;
      srcFlit[p]  = 0;
    end
    srcOn = mask;
    driveSources();
  endtask

  // One clock: sample handshakes at the falling edge, then advance sources just after the rising edge.
  task automatic cycleStep();
    logic [3:0] fire;
    @(negedge clk);
    for (int p = 0; p < 4; p++) fire[p] = inReady[p] && !inStop[p];
    if (smiOutReady && !smiOutStop) rxQ.push_back({smiOutEofc, smiOutData});
    if (smiOutReady) rxStarted = 1'b1;
    else if (rxStarted) rxGaps++;
    @(posedge clk);
    #1;
    for (int p = 0; p < 4; p++) begin
      if (fire[p]) begin
        srcFlit[p]++;
        if (srcFlit[p] == srcLen[p]) begin
          srcFlit[p] = 0;
          srcFrame[p]++;
        end
      end
    end
    driveSources();
    smiOutStop = randStop ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  task automatic resetDut();
    arstn    = 1'b0;
    randStop = 1'b0;
    smiOutStop = 1'b0;
    startSources(4'b0000, 1, 1, 1, 1);
    repeat (2) @(posedge clk);
    #1;
    arstn = 1'b1;
    rxQ.delete();
    rxStarted = 1'b0;
    rxGaps    = 0;
    @(posedge clk);
    #1;
  endtask

  // Every port's flits must arrive in order with correct Eofc, and frames must never interleave.
  task automatic checkStream(input string tag);
    int         nextFrame [4];
    int         nextFlit [4];
    int         p;
    int         prevPort;
    bit         prevLast;
    logic [23:0] e;
    for (int q = 0; q < 4; q++) begin
      nextFrame[q] = 0;
      nextFlit[q]  = 0;
    end
    prevLast = 1'b1;
    prevPort = 0;
    foreach (rxQ[i]) begin
      e = rxQ[i];
      p = int'(e[15:12]);
      if (p > 3 || srcLen[p & 3] == 0) begin
        checkOutput({tag, "PortRange"}, 32'(p), 32'(prevPort));
        continue;
      end
      checkOutput({tag, "Seq"}, {20'd0, e[11:0]}, {20'd0, 8'(nextFrame[p]), 4'(nextFlit[p])});
      checkOutput({tag, "Eofc"}, 32'(e[23:16]), (nextFlit[p] == srcLen[p] - 1) ? 32'h02 : 32'h00);
      if (!prevLast) checkOutput({tag, "Interleave"}, 32'(p), 32'(prevPort));
      prevLast = (int'(e[3:0]) == srcLen[p] - 1);
      prevPort = p;
      nextFlit[p]++;
      if (nextFlit[p] == srcLen[p]) begin
        nextFlit[p] = 0;
        nextFrame[p]++;
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    inReady[v.port] = 1'b1;
    inEofc[v.port]  = v.eofc;
    inData[v.port]  = v.data;
    @(posedge clk);
    #1;
    inReady[v.port] = 1'b0;
    checkOutput("vecStopWhileWaiting", 32'(inStop[v.port]), 1);
    checkOutput("vecNoEarlyGrant", 32'(schedGrantValid), 0);
    @(posedge clk);
    #1;
    checkOutput("vecGrantValid", 32'(schedGrantValid), 1);
    checkOutput("vecGrantPort", 32'(schedGrantPort), 32'(v.port));
    checkOutput("vecNoEarlyOut", 32'(smiOutReady), 0);
    @(posedge clk);
    #1;
    checkOutput("vecOutReady", 32'(smiOutReady), 1);
    checkOutput("vecOutEofc", 32'(smiOutEofc), 32'(v.expEofc));
    checkOutput("vecOutData", 32'(smiOutData), 32'(v.expData));
    checkOutput("vecBackToIdle", 32'(schedGrantValid), 0);
    @(posedge clk);
    #1;
    checkOutput("vecOutDrained", 32'(smiOutReady), 0);
  endtask

  initial begin
    logic [23:0] e;
    bit          found;

    vecs[0] = '{port: 0, eofc: 8'h01, data: 16'hA5A5, expEofc: 8'h01, expData: 16'hA5A5};
    vecs[1] = '{port: 1, eofc: 8'hFF, data: 16'h1234, expEofc: 8'h03, expData: 16'h1234};
    vecs[2] = '{port: 2, eofc: 8'h06, data: 16'hBEEF, expEofc: 8'h02, expData: 16'hBEEF};
    vecs[3] = '{port: 3, eofc: 8'h42, data: 16'h0F0F, expEofc: 8'h02, expData: 16'h0F0F};
    vecs[4] = '{port: 2, eofc: 8'h03, data: 16'hFFFF, expEofc: 8'h03, expData: 16'hFFFF};

    numCompared   = 0;
    numMismatched = 0;
    arstn      = 1'b0;
    smiOutStop = 1'b0;
    randStop   = 1'b0;
    cfgEnable  = 4'b1111;
    cfgQuota   = 16'h1111;
    startSources(4'b0000, 1, 1, 1, 1);
    rxStarted = 1'b0;
    rxGaps    = 0;

    @(posedge clk);
    @(posedge clk);
    #1;
    $display("[TB] reset values");
    checkOutput("rstInStop", 32'(inStop), 0);
    checkOutput("rstOutReady", 32'(smiOutReady), 0);
    checkOutput("rstGrantValid", 32'(schedGrantValid), 0);
    resetDut();

    $display("[TB] single-flit vectors");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i]);
      @(posedge clk);
      #1;
    end

    $display("[TB] round-robin, quota 1, 2-flit frames");
    resetDut();
    cfgEnable = 4'b1111;
    cfgQuota  = 16'h1111;
    startSources(4'b1111, 2, 2, 2, 2);
    repeat (30) cycleStep();
    checkOutput("rrCount", 32'(rxQ.size() >= 16), 1);
    for (int k = 0; k < 16 && k < rxQ.size(); k++) begin
      e = rxQ[k];
      checkOutput("rrOrderPort", 32'(e[15:12]), 32'((k / 2) % 4));
      checkOutput("rrOrderFrameFlit", 32'(e[11:0]), {20'd0, 8'(k / 8), 4'(k % 2)});
    end
    checkOutput("rrNoIdleGap", 32'(rxGaps), 0);
    checkStream("rr");

    $display("[TB] quota p0=3 p1=1");
    resetDut();
    cfgEnable = 4'b1111;
    cfgQuota  = 16'h0013;
    startSources(4'b0011, 1, 1, 1, 1);
    repeat (40) cycleStep();
    checkOutput("quotaCount", 32'(rxQ.size() >= 16), 1);
    for (int k = 0; k < 16 && k < rxQ.size(); k++) begin
      e = rxQ[k];
      checkOutput("quotaPattern", 32'(e[15:12]), (k % 4 == 3) ? 1 : 0);
    end
    checkStream("quota");

    $display("[TB] quota field 0 means 16 frames");
    resetDut();
    cfgEnable = 4'b1111;
    cfgQuota  = 16'h0010;
    startSources(4'b0011, 1, 1, 1, 1);
    repeat (45) cycleStep();
    checkOutput("quota16Count", 32'(rxQ.size() >= 34), 1);
    for (int k = 0; k < 34 && k < rxQ.size(); k++) begin
      e = rxQ[k];
      checkOutput("quota16Pattern", 32'(e[15:12]), (k % 17 == 16) ? 1 : 0);
    end

    $display("[TB] disabled port 2");
    resetDut();
    cfgEnable = 4'b1011;
    cfgQuota  = 16'h1111;
    startSources(4'b0101, 1, 1, 1, 1);
    for (int c = 0; c < 40; c++) begin
      cycleStep();
      checkOutput("disStop2", 32'(inStop[2]), 1);
      if (schedGrantValid) checkOutput("disNeverGrant2", 32'(schedGrantPort == 2'd2), 0);
    end
    found = 1'b0;
    foreach (rxQ[i]) if (rxQ[i][15:12] == 4'd2) found = 1'b1;
    checkOutput("disNoP2Output", 32'(found), 0);
    checkOutput("disP0Flows", 32'(rxQ.size() > 20), 1);

    $display("[TB] lone requester p3, quota 2");
    resetDut();
    cfgEnable = 4'b1111;
    cfgQuota  = 16'h2111;
    startSources(4'b1000, 1, 1, 1, 1);
    for (int c = 0; c < 30; c++) begin
      cycleStep();
      if (c >= 2) checkOutput("loneGrant", {29'd0, schedGrantValid, schedGrantPort}, 32'b111);
    end
    checkOutput("loneNoGap", 32'(rxGaps), 0);
    checkOutput("loneCount", 32'(rxQ.size() >= 25), 1);
    checkStream("lone");

    $display("[TB] random output stop, all ports");
    resetDut();
    cfgEnable = 4'b1111;
    cfgQuota  = 16'h2131;
    startSources(4'b1111, 1, 2, 3, 4);
    randStop = 1'b1;
    repeat (400) cycleStep();
    randStop   = 1'b0;
    smiOutStop = 1'b0;
    checkOutput("randProgress", 32'(rxQ.size() > 100), 1);
    checkStream("rand");

    $display("[TB] reset mid-frame on port 1");
    resetDut();
    cfgEnable = 4'b1111;
    cfgQuota  = 16'h1111;
    startSources(4'b0011, 4, 4, 1, 1);
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      cycleStep();
      if (schedGrantValid && schedGrantPort == 2'd1) found = 1'b1;
    end
    checkOutput("rstWaitP1Grant", 32'(found), 1);
    repeat (2) cycleStep();
    #2;
    arstn = 1'b0;
    #1;
    checkOutput("rstAsyncInStop", 32'(inStop), 0);
    checkOutput("rstAsyncOutReady", 32'(smiOutReady), 0);
    checkOutput("rstAsyncGrantValid", 32'(schedGrantValid), 0);
    startSources(4'b0000, 4, 4, 1, 1);
    repeat (2) @(posedge clk);
    #1;
    arstn = 1'b1;
    rxQ.delete();
    rxStarted = 1'b0;
    rxGaps    = 0;
    startSources(4'b0011, 4, 4, 1, 1);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      cycleStep();
      if (schedGrantValid) found = 1'b1;
    end
    checkOutput("rstRegrantSeen", 32'(found), 1);
    checkOutput("rstRegrantPort", 32'(schedGrantPort), 0);
    repeat (30) cycleStep();
    checkOutput("rstRxCount", 32'(rxQ.size() > 8), 1);
    if (rxQ.size() > 0) begin
      e = rxQ[0];
      checkOutput("rstFirstFlit", 32'(e[15:0]), 32'h0000);
    end
    checkStream("rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule

// File: doc/smi_frame_scheduler_x4.md
SMI_FRAME_SCHEDULER_X4 -- requirements
Module: smi_frame_scheduler_x4

Interface
REQ-001 SHALL have parameters: FlitWidth, default 2, SMI flit width in bytes.
REQ-002 SHALL have parameters: FifoSize, default 16, output FIFO depth (>3).
REQ-003 SHALL have parameters: FifoIndexSize, default 4, bits to hold FifoSize-1.
REQ-004 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- arstn  in  1  asynchronous active-low reset.
REQ-005 SHALL have, for each p in 0..3, ports:
- smiInReady<p>  in  1  flit valid.
- smiInEofc<p>  in  8  end-of-frame control; nonzero marks the last flit.
- smiInData<p>  in  FlitWidth*8  payload.
- smiInStop<p>  out  1  backpressure.
REQ-006 SHALL have output ports:
- smiOutReady  out  1
- smiOutEofc  out  8
- smiOutData  out  FlitWidth*8
- smiOutStop  in  1
REQ-007 SHALL have config ports:
- cfgEnable  in  4  per-port arbitration enable.
- cfgQuota  in  16  4-bit frames-per-turn for each port; port p uses bits [4p+3:4p].
REQ-008 SHALL have status ports:
- schedGrantValid  out  1  a port holds the grant.
- schedGrantPort  out  2  index of the granted port.

Function
REQ-009 SHALL register each input port with a hold-when-stopped stage.
REQ-010 The input stage SHALL define smiInStop<p> = Ready_q<p> & Halt<p>; a flit is transferred when Ready and not Stop.
REQ-011 The input stage SHALL mask stored Eofc with 2*FlitWidth-1 and register Last = (Eofc != 0).
REQ-012 SHALL use FSM states IDLE and XFER, plus a 2-bit grant register, a 2-bit round-robin pointer and a 4-bit quota counter.
REQ-013 In IDLE, SHALL select the first port with Ready_q and enable set, searching from the pointer upward modulo 4, and SHALL enter XFER on the next edge with quota counter = cfgQuota of that port.
REQ-014 A quota field of 0 SHALL be treated as 16 frames.
REQ-015 In XFER, SHALL pass only the granted port's registered flit to the buffer; all other ports SHALL be halted.
REQ-016 On acceptance of a Last flit with quota counter > 1, the port still ready and still enabled: SHALL keep the grant and decrement the counter.
REQ-017 On acceptance of a Last flit otherwise: SHALL move the pointer to grant+1 and re-arbitrate in the same cycle (zero wait states); the current port is eligible only after all others, so a lone requester is re-granted with its quota reloaded.
REQ-018 If no port is eligible after a Last flit, SHALL return to IDLE.
REQ-019 A cfgEnable deassertion mid-frame SHALL NOT truncate the frame; it takes effect at the frame boundary.
REQ-020 cfgQuota SHALL be sampled only at grant load.
REQ-021 Latency: a flit presented to an idle block with the FIFO empty SHALL appear at smiOutReady 3 cycles later (input register, grant, FIFO).
REQ-022 smiOutStop SHALL propagate back only to the granted port; no flit SHALL be lost or duplicated under any stop pattern.
REQ-023 schedGrantValid SHALL be 1 exactly in XFER; schedGrantPort SHALL equal the grant register.

Reset
REQ-024 On arstn low, asynchronously: FSM=IDLE, pointer=0, grant=0, quota counter=0, all Ready_q=0, FIFO empty.
REQ-025 Resulting reset values: all smiInStop=0, smiOutReady=0, schedGrantValid=0.
REQ-026 Datapath registers (Eofc/Data/Last) SHALL be non-resettable.
REQ-027 Reset assertion mid-frame SHALL discard the partial frame; after release, arbitration restarts from port 0.

Structure
REQ-028 A shared package SHALL hold the FSM state encodings, the quota-0 value (16) and the Eofc mask derivation.
REQ-029 SHALL instantiate the existing selfLinkBufferFifoS as the single sub-module, width (FlitWidth+1)*8, with its reset driven from arstn via a local reset synchronizer.
REQ-030 Round-robin search SHALL be a combinational function within the module.

Verification
REQ-031 Bench SHALL cover: all ports enabled, quota=1, each sending 2-flit frames continuously -> output frame order 0,1,2,3,0,... with no idle cycle between frames.
REQ-032 Bench SHALL cover: cfgQuota=0x0013 (p0=3, p1=1), p0 and p1 always ready -> pattern p0,p0,p0,p1 repeating.
REQ-033 Bench SHALL cover: cfgEnable=4'b1011, p2 ready -> p2 never granted and smiInStop2 stays 1 once its flit is registered.
REQ-034 Bench SHALL cover: random smiOutStop at 50% with 4 ports active -> scoreboard receives every flit in frame order per port, with frames never interleaved.
REQ-035 Bench SHALL cover: arstn pulsed low mid-frame on p1 -> all outputs at reset values within the same cycle; the next granted frame starts at port 0 if it is ready.
REQ-036 Bench SHALL cover: only p3 ready, quota=2, 1-flit frames -> p3 is re-granted back-to-back and the output is valid every cycle.
